// File: rtl/dcache_direct_wb.sv
// Direct-mapped write-back write-allocate data cache between MEM stage and memory.
// Ports: proc_* word request/stall interface, mem_* 128-bit block refill/write-back.
module dcache_direct_wb #(
   parameter int LINES = 8,
   parameter int IW    = $clog2(LINES),
   parameter int TW    = 28 - IW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         proc_read,
   input  logic         proc_write,
   input  logic [29:0]  proc_addr,
   input  logic [31:0]  proc_wdata,
   output logic [31:0]  proc_rdata,
   output logic         proc_stall,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);

   localparam logic [1:0] S_COMPARE   = 2'd0;
   localparam logic [1:0] S_WRITEBACK = 2'd1;
   localparam logic [1:0] S_ALLOCATE  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [LINES-1:0] valid_q, valid_d;
   logic [LINES-1:0] dirty_q, dirty_d;
   logic [TW-1:0]    tag_q  [LINES];
   logic [TW-1:0]    tag_d  [LINES];
   logic [127:0]     data_q [LINES];
   logic [127:0]     data_d [LINES];

   logic [IW-1:0]    idx;
   logic [TW-1:0]    req_tag;
   logic [6:0]       bit_off;
   logic [127:0]     line;
   logic             req;
   logic             hit;

   assign idx     = proc_addr[IW+1:2];
   assign req_tag = proc_addr[29:IW+2];
   assign bit_off = {proc_addr[1:0], 5'b0};
   assign line    = data_q[idx];
   assign req     = proc_read | proc_write;
   assign hit     = valid_q[idx] && (tag_q[idx] == req_tag);

   // Memory side is a pure decode of the registered state.
   assign mem_read   = (state_q == S_ALLOCATE);
   assign mem_write  = (state_q == S_WRITEBACK);
   assign mem_addr   = mem_write ? {tag_q[idx], idx} : proc_addr[29:2];
   assign mem_wdata  = line;
   assign proc_rdata = line[bit_off +: 32];

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      dirty_d    = dirty_q;
      tag_d      = tag_q;
      data_d     = data_q;
      proc_stall = 1'b1;
      unique case (state_q)
         S_COMPARE: begin
            proc_stall = 1'b0;
            if (req) begin
               if (hit) begin
                  // Write wins when read and write are both raised.
                  if (proc_write) begin
                     data_d[idx][bit_off +: 32] = proc_wdata;
                     dirty_d[idx]               = 1'b1;
                  end
               end else begin
                  proc_stall = 1'b1;
                  if (valid_q[idx] && dirty_q[idx]) begin
                     state_d = S_WRITEBACK;
                  end else begin
                     state_d = S_ALLOCATE;
                  end
               end
            end
         end
         S_WRITEBACK: begin
            if (mem_ready) begin
               dirty_d[idx] = 1'b0;
               state_d      = S_ALLOCATE;
            end
         end
         S_ALLOCATE: begin
            // The held request replays as a hit once the fill lands.
            if (mem_ready) begin
               data_d[idx]  = mem_rdata;
               tag_d[idx]   = req_tag;
               valid_d[idx] = 1'b1;
               dirty_d[idx] = 1'b0;
               state_d      = S_COMPARE;
            end
         end
         default: begin
            state_d = S_COMPARE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_COMPARE;
         valid_q <= '0;
         dirty_q <= '0;
         for (int i = 0; i < LINES; i++) begin
            tag_q[i]  <= '0;
            data_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         tag_q   <= tag_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_dcache_direct_wb.sv
// Directed self-checking bench for dcache_direct_wb.
// Drives requests at posedge+1, samples mid-cycle, plays the memory side.
module tb_dcache_direct_wb;

   logic         clk = 1'b0;
   logic         rst;
   logic         proc_read, proc_write;
   logic [29:0]  proc_addr;
   logic [31:0]  proc_wdata;
   logic [31:0]  proc_rdata;
   logic         proc_stall;
   logic         mem_read, mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata;
   logic         mem_ready;

   int n_cmp = 0;
   int n_bad = 0;

   int           r_stalls, r_rd_cyc, r_wr_cyc;
   logic [27:0]  r_rd_addr, r_wr_addr;
   logic [127:0] r_wr_data;
   logic [31:0]  r_rdata;
   bit           r_timeout, r_chg;
   bit           r_both = 0;

   localparam logic [127:0] BLK0 = {32'h33, 32'h22, 32'h11, 32'h10};
   localparam logic [127:0] BLKA = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
   localparam logic [127:0] BLKB = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
   localparam logic [127:0] BLKC = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
   localparam logic [127:0] BLKD = {32'hD3, 32'hD2, 32'hD1, 32'hD0};

   always #5 clk = ~clk;

   dcache_direct_wb dut (
      .clk        (clk),
      .rst        (rst),
      .proc_read  (proc_read),
      .proc_write (proc_write),
      .proc_addr  (proc_addr),
      .proc_wdata (proc_wdata),
      .proc_rdata (proc_rdata),
      .proc_stall (proc_stall),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   // Holds one request until stall drops, acting as memory: each transfer
   // phase gets mem_ready on its (dly+1)-th cycle. Records what it saw.
   task automatic run_req(input logic rd, input logic wr,
                          input logic [29:0] a, input logic [31:0] wd,
                          input logic [127:0] blk, input int dly);
      int ph;
      bit done;
      ph = 0;
      done = 0;
      r_stalls = 0; r_rd_cyc = 0; r_wr_cyc = 0;
      r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0;
      r_rdata = '0; r_timeout = 0; r_chg = 0;
      proc_read = rd; proc_write = wr;
      proc_addr = a; proc_wdata = wd; mem_rdata = blk;
      for (int c = 0; c < 60 && !done; c++) begin
         #2;
         if (mem_read && mem_write) r_both = 1;
         if (!proc_stall) begin
            r_rdata = proc_rdata;
            done = 1;
         end else begin
            r_stalls++;
            if (mem_write) begin
               if (r_wr_cyc == 0) begin
                  r_wr_addr = mem_addr;
                  r_wr_data = mem_wdata;
               end else if (mem_addr !== r_wr_addr ||
                            mem_wdata !== r_wr_data) begin
                  r_chg = 1;
               end
               r_wr_cyc++;
            end
            if (mem_read) begin
               if (r_rd_cyc == 0) r_rd_addr = mem_addr;
               else if (mem_addr !== r_rd_addr) r_chg = 1;
               r_rd_cyc++;
            end
            if (mem_read || mem_write) begin
               ph++;
               if (ph > dly) begin
                  mem_ready = 1'b1;
                  ph = 0;
               end
            end
         end
         @(posedge clk);
         #1;
         mem_ready = 1'b0;
      end
      if (!done) r_timeout = 1;
      proc_read = 1'b0;
      proc_write = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      proc_read = 0; proc_write = 0;
      proc_addr = '0; proc_wdata = '0;
      mem_rdata = '0; mem_ready = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #2;
      n_cmp++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_memreq: rd=%b wr=%b, want 0 0",
                  mem_read, mem_write);
      end
      n_cmp++;
      if (proc_stall !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_stall: got %b want 0", proc_stall);
      end
      n_cmp++;
      if (proc_rdata !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_rdata: got %h want 0", proc_rdata);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_read_miss;
      run_req(1, 0, 30'h04, 32'h0, BLK0, 3);
      n_cmp++;
      if (r_timeout || r_rdata !== 32'h10) begin
         n_bad++;
         $display("FAIL miss_rdata: got %h (to=%0d) want 10",
                  r_rdata, r_timeout);
      end
      n_cmp++;
      if (r_stalls != 5) begin
         n_bad++;
         $display("FAIL miss_stalls: got %0d want 5", r_stalls);
      end
      n_cmp++;
      if (r_rd_addr !== 28'h1 || r_rd_cyc < 3 || r_chg) begin
         n_bad++;
         $display("FAIL miss_memaddr: got %h cyc=%0d chg=%0d want 1",
                  r_rd_addr, r_rd_cyc, r_chg);
      end
      n_cmp++;
      if (r_wr_cyc != 0) begin
         n_bad++;
         $display("FAIL miss_nowb: got %0d want 0", r_wr_cyc);
      end
   endtask

   task automatic test_back_to_back;
      logic [29:0] a [3];
      logic [31:0] e [3];
      a[0] = 30'h05; a[1] = 30'h06; a[2] = 30'h07;
      e[0] = 32'h11; e[1] = 32'h22; e[2] = 32'h33;
      for (int i = 0; i < 3; i++) begin
         run_req(1, 0, a[i], 32'h0, BLK0, 1);
         n_cmp++;
         if (r_timeout || r_rdata !== e[i] ||
             r_stalls != 0 || r_rd_cyc != 0) begin
            n_bad++;
            $display("FAIL hit_%0d: got %h st=%0d rd=%0d want %h st=0",
                     i, r_rdata, r_stalls, r_rd_cyc, e[i]);
         end
      end
   endtask

   task automatic test_dirty_evict;
      run_req(0, 1, 30'h04, 32'hDEADBEEF, BLK0, 1);
      n_cmp++;
      if (r_timeout || r_stalls != 0) begin
         n_bad++;
         $display("FAIL whit_stall: got %0d want 0", r_stalls);
      end
      run_req(1, 0, 30'h24, 32'h0, BLKA, 1);
      n_cmp++;
      if (r_wr_cyc != 2 || r_wr_addr !== 28'h1) begin
         n_bad++;
         $display("FAIL wb_addr: got %h cyc=%0d want 1 cyc=2",
                  r_wr_addr, r_wr_cyc);
      end
      n_cmp++;
      if (r_wr_data !== {32'h33, 32'h22, 32'h11, 32'hDEADBEEF}) begin
         n_bad++;
         $display("FAIL wb_data: got %h want 33/22/11/deadbeef", r_wr_data);
      end
      n_cmp++;
      if (r_rd_addr !== 28'h9 || r_chg) begin
         n_bad++;
         $display("FAIL evict_fill: got %h chg=%0d want 9",
                  r_rd_addr, r_chg);
      end
      n_cmp++;
      if (r_timeout || r_rdata !== 32'hA0 || r_stalls != 5) begin
         n_bad++;
         $display("FAIL evict_rdata: got %h st=%0d want a0 st=5",
                  r_rdata, r_stalls);
      end
      run_req(1, 0, 30'h04, 32'h0, {32'h33, 32'h22, 32'h11, 32'hDEADBEEF}, 1);
      n_cmp++;
      if (r_wr_cyc != 0 || r_rd_addr !== 28'h1 || r_rdata !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL reread_clean: wr=%0d a=%h d=%h want 0 1 deadbeef",
                  r_wr_cyc, r_rd_addr, r_rdata);
      end
   endtask

   task automatic test_write_miss;
      run_req(0, 1, 30'h4A, 32'hCAFE0001, BLKB, 1);
      n_cmp++;
      if (r_timeout || r_wr_cyc != 0 || r_rd_addr !== 28'h12 ||
          r_stalls != 3) begin
         n_bad++;
         $display("FAIL wmiss_fill: a=%h wr=%0d st=%0d want 12 0 3",
                  r_rd_addr, r_wr_cyc, r_stalls);
      end
      run_req(1, 0, 30'h4A, 32'h0, BLKB, 1);
      n_cmp++;
      if (r_rdata !== 32'hCAFE0001 || r_stalls != 0) begin
         n_bad++;
         $display("FAIL wmiss_merge: got %h st=%0d want cafe0001 0",
                  r_rdata, r_stalls);
      end
      run_req(1, 0, 30'h0A, 32'h0, BLKC, 1);
      n_cmp++;
      if (r_wr_cyc != 2 || r_wr_addr !== 28'h12 ||
          r_wr_data !== {32'hB3, 32'hCAFE0001, 32'hB1, 32'hB0}) begin
         n_bad++;
         $display("FAIL wmiss_wb: a=%h d=%h cyc=%0d want 12 b3/cafe0001/b1/b0",
                  r_wr_addr, r_wr_data, r_wr_cyc);
      end
      n_cmp++;
      if (r_rd_addr !== 28'h2 || r_rdata !== 32'hC2) begin
         n_bad++;
         $display("FAIL wmiss_refill: a=%h d=%h want 2 c2",
                  r_rd_addr, r_rdata);
      end
   endtask

   task automatic test_reset_mid_alloc;
      proc_read = 1'b1;
      proc_addr = 30'h104;
      @(posedge clk);
      #1;
      n_cmp++;
      if (mem_read !== 1'b1 || mem_addr !== 28'h41) begin
         n_bad++;
         $display("FAIL rstm_alloc: rd=%b a=%h want 1 41", mem_read, mem_addr);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      proc_read = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (mem_read !== 1'b0 || proc_stall !== 1'b0) begin
         n_bad++;
         $display("FAIL rstm_drop: rd=%b st=%b want 0 0", mem_read, proc_stall);
      end
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      #1;
      n_cmp++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
         n_bad++;
         $display("FAIL rstm_late: rd=%b wr=%b want 0 0", mem_read, mem_write);
      end
      run_req(1, 0, 30'h104, 32'h0, BLKD, 1);
      n_cmp++;
      if (r_timeout || r_stalls != 3 || r_rd_cyc != 2 || r_rdata !== 32'hD0) begin
         n_bad++;
         $display("FAIL rstm_remiss: st=%0d rd=%0d d=%h want 3 2 d0",
                  r_stalls, r_rd_cyc, r_rdata);
      end
   endtask

   task automatic test_spurious_rw;
      mem_ready = 1'b1;
      #2;
      n_cmp++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || proc_stall !== 1'b0) begin
         n_bad++;
         $display("FAIL spur_idle: rd=%b wr=%b st=%b want 0 0 0",
                  mem_read, mem_write, proc_stall);
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      run_req(1, 0, 30'h104, 32'h0, BLKA, 1);
      n_cmp++;
      if (r_stalls != 0 || r_rd_cyc != 0 || r_rdata !== 32'hD0) begin
         n_bad++;
         $display("FAIL spur_state: st=%0d d=%h want 0 d0", r_stalls, r_rdata);
      end
      run_req(1, 0, 30'h04, 32'h0, BLK0, 1);
      run_req(1, 1, 30'h04, 32'h1, BLK0, 1);
      n_cmp++;
      if (r_timeout || r_stalls != 0 || r_wr_cyc != 0) begin
         n_bad++;
         $display("FAIL rw_hit: st=%0d wr=%0d want 0 0", r_stalls, r_wr_cyc);
      end
      run_req(1, 0, 30'h04, 32'h0, BLK0, 1);
      n_cmp++;
      if (r_rdata !== 32'h1 || r_stalls != 0) begin
         n_bad++;
         $display("FAIL rw_as_write: got %h st=%0d want 1 0", r_rdata, r_stalls);
      end
      n_cmp++;
      if (r_both) begin
         n_bad++;
         $display("FAIL rd_wr_excl: both seen=%0d want 0", r_both);
      end
   endtask

   initial begin
      test_reset();
      test_read_miss();
      test_back_to_back();
      test_dirty_evict();
      test_write_miss();
      test_reset_mid_alloc();
      test_spurious_rw();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
